// File: rtl/adc_scan_ctrl_pkg.sv
// Shared definitions for the LTC2308-class scan controller: FSM encoding,
// config-word layout and channel-sequencing helpers.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT,
        ST_SHIFT,
        ST_ACQ
    } state_t;

    localparam int CFG_W   = 6;
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    function automatic logic [CFG_W-1:0] ch2cfg(input logic [2:0] ch, input logic uni);
        logic [CFG_W-1:0] c;
        c          = '0;
        c[CFG_SD]  = 1'b1;
        c[CFG_OS]  = ch[0];
        c[CFG_S1]  = ch[2];
        c[CFG_S0]  = ch[1];
        c[CFG_UNI] = uni;
        c[CFG_SLP] = 1'b0;
        return c;
    endfunction

    // Lowest enabled channel above cur; wraps to the lowest enabled channel.
    function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (mask[i]) r = i[2:0];
        for (int i = 7; i >= 0; i--)
            if (mask[i] && (i > int'(cur))) r = i[2:0];
        return r;
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// ADC pin bundle: the controller drives CONVST/SCK/SDI and receives SDO.
interface adc_scan_ctrl_if;
    logic adc_convst;
    logic adc_sck;
    logic adc_sdi;
    logic adc_sdo;

    modport master (output adc_convst, adc_sck, adc_sdi, input adc_sdo);
    modport slave  (input adc_convst, adc_sck, adc_sdi, output adc_sdo);
endinterface

// File: rtl/adc_scan_ctrl_shift.sv
// One SPI frame: SCK divider, config word out on SDI, DATA_W result bits in from SDO.
module adc_spi_shift
    import adc_scan_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [CFG_W-1:0]  cfg,
    output logic              done,
    output logic [DATA_W-1:0] data,
    output logic              sck,
    output logic              sdi,
    input  logic              sdo
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic             active;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    nbit;
    logic [CFG_W-1:0] cfg_sr;

    // SDI and SDO both move on the SCK falling edge, so SDI is stable for the whole low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            nbit   <= '0;
            cfg_sr <= '0;
            data   <= '0;
            done   <= 1'b0;
            sck    <= 1'b0;
            sdi    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (go) begin
                    active <= 1'b1;
                    cnt    <= '0;
                    nbit   <= '0;
                    sdi    <= cfg[CFG_W-1];
                    cfg_sr <= {cfg[CFG_W-2:0], 1'b0};
                end
            end else if (cnt == HALF_END) begin
                cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck    <= 1'b0;
                    data   <= {data[DATA_W-2:0], sdo};
                    sdi    <= cfg_sr[CFG_W-1];
                    cfg_sr <= {cfg_sr[CFG_W-2:0], 1'b0};
                    if (nbit == LAST_BIT) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                        sdi    <= 1'b0;
                    end else begin
                        nbit <= nbit + BW'(1);
                    end
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scan controller for an LTC2308-class SAR ADC: frame FSM, channel sequencing and
// re-tagging of results that arrive one frame after their config word.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 8,
    parameter int CONVST_CYC = 2,
    parameter int CONV_CYC   = 80,
    parameter int ACQ_CYC    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic               uni,
    output logic               busy,
    adc_scan_ctrl_if.master    adc,
    output logic               res_valid,
    output logic [2:0]         res_ch,
    output logic [DATA_W-1:0]  res_data,
    output logic               scan_done
);
    localparam int FRAME = CONV_CYC + 2 * CLK_DIV * DATA_W + ACQ_CYC;
    localparam int TW    = $clog2(FRAME);
    localparam logic [TW-1:0] T_CONV_END = TW'(CONVST_CYC - 1);
    // go is issued one SCK half-period early so the first rise lands exactly on CONV_CYC.
    localparam logic [TW-1:0] T_GO       = TW'(CONV_CYC - CLK_DIV - 1);
    localparam logic [TW-1:0] T_END      = TW'(FRAME - 1);

    state_t            state, next_state;
    logic [TW-1:0]     tcnt;
    logic [7:0]        mask_q, mask_in;
    logic              uni_q;
    logic [2:0]        send_ch, rd_ch;
    logic              send_vld, rd_vld;
    logic              go, done, scan_req;
    logic [CFG_W-1:0]  cfg_word;
    logic [DATA_W-1:0] shift_data;

    assign mask_in  = 8'(ch_mask);
    assign scan_req = (start | en) & (|ch_mask);
    assign busy     = (state != ST_IDLE);
    assign cfg_word = ch2cfg(send_ch, uni_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        go         = 1'b0;
        case (state)
            ST_IDLE:  if (scan_req) next_state = ST_CONV;
            ST_CONV:  if (tcnt == T_CONV_END) next_state = ST_WAIT;
            ST_WAIT:  if (tcnt == T_GO) begin
                          go         = 1'b1;
                          next_state = ST_SHIFT;
                      end
            ST_SHIFT: if (done) next_state = ST_ACQ;
            ST_ACQ:   if (tcnt == T_END) next_state = rd_vld ? ST_CONV : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Frame timer restarts on every CONVST rise; the result stage tags the frame's readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt           <= '0;
            mask_q         <= '0;
            uni_q          <= 1'b0;
            send_ch        <= '0;
            send_vld       <= 1'b0;
            rd_ch          <= '0;
            rd_vld         <= 1'b0;
            adc.adc_convst <= 1'b0;
            res_valid      <= 1'b0;
            res_ch         <= '0;
            res_data       <= '0;
            scan_done      <= 1'b0;
        end else begin
            adc.adc_convst <= (next_state == ST_CONV);
            res_valid      <= 1'b0;
            scan_done      <= 1'b0;
            if (state == ST_IDLE || (next_state == ST_CONV && state != ST_CONV))
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);

            if (state == ST_IDLE && scan_req) begin
                mask_q   <= mask_in;
                uni_q    <= uni;
                send_ch  <= next_ch(mask_in, 3'd7);
                send_vld <= 1'b1;
                rd_vld   <= 1'b0;
            end

            if (state == ST_SHIFT && done) begin
                res_valid <= rd_vld;
                scan_done <= rd_vld && (next_ch(mask_q, rd_ch) <= rd_ch);
                if (rd_vld) begin
                    res_ch   <= rd_ch;
                    res_data <= shift_data;
                end
                rd_ch    <= send_ch;
                rd_vld   <= send_vld;
                send_ch  <= next_ch(mask_q, send_ch);
                // Past the last channel: keep going when en is high, else one flush frame.
                send_vld <= send_vld && ((next_ch(mask_q, send_ch) > send_ch) || en);
            end
        end
    end

    adc_spi_shift #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .cfg   (cfg_word),
        .done  (done),
        .data  (shift_data),
        .sck   (adc.adc_sck),
        .sdi   (adc.adc_sdi),
        .sdo   (adc.adc_sdo)
    );

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural LTC2308 (CH0..CH7 = FFF..888).
module tb_adc_scan_ctrl;
    localparam int CLK_DIV    = 2;
    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 8;
    localparam int CONVST_CYC = 2;
    localparam int CONV_CYC   = 80;
    localparam int ACQ_CYC    = 10;
    localparam int FRAME      = CONV_CYC + 2 * CLK_DIV * DATA_W + ACQ_CYC;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              start = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              uni = 1'b0;
    logic              busy, res_valid, scan_done;
    logic [2:0]        res_ch;
    logic [DATA_W-1:0] res_data;

    int tests = 0;
    int fails = 0;

    adc_scan_ctrl_if adc_bus ();

    adc_scan_ctrl #(
        .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .NUM_CH(NUM_CH),
        .CONVST_CYC(CONVST_CYC), .CONV_CYC(CONV_CYC), .ACQ_CYC(ACQ_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .ch_mask(ch_mask), .uni(uni),
        .busy(busy), .adc(adc_bus), .res_valid(res_valid), .res_ch(res_ch),
        .res_data(res_data), .scan_done(scan_done)
    );

    always #10 clk = ~clk;

    // ADC model: conversion channel comes from the config word of the previous frame.
    logic [DATA_W-1:0] adc_word = '0;
    logic [5:0]        cfg_sr = '0;
    logic [5:0]        cfg_last = '0;
    logic [2:0]        conv_ch = '0;
    int                cfg_bits = 0;
    logic              cv_m = 1'b0;
    logic              sck_m = 1'b0;
    logic [5:0]        sdi_q[$];

    assign adc_bus.adc_sdo = adc_word[DATA_W-1];

    always @(adc_bus.adc_convst or adc_bus.adc_sck) begin
        if (adc_bus.adc_convst && !cv_m) begin
            conv_ch  = {cfg_last[3], cfg_last[2], cfg_last[4]};
            adc_word = 12'hFFF - 12'h111 * 12'(conv_ch);
            cfg_bits = 0;
        end
        if (!adc_bus.adc_sck && sck_m) adc_word = {adc_word[DATA_W-2:0], 1'b0};
        if (adc_bus.adc_sck && !sck_m) begin
            cfg_sr = {cfg_sr[4:0], adc_bus.adc_sdi};
            cfg_bits++;
            if (cfg_bits == 6) begin
                cfg_last = cfg_sr;
                sdi_q.push_back(cfg_sr);
            end
        end
        cv_m  = adc_bus.adc_convst;
        sck_m = adc_bus.adc_sck;
    end

    // Pin timing and result capture, sampled on the inactive clock edge.
    int cyc = 0, cv_rise_cyc = -1, cv_width = 0, first_off = 0, period = 0, rises = 0;
    int sck_rise_cyc = 0, sck_fall_cyc = 0, hw_err = 0, sdi_err = 0, conv_cnt = 0;
    logic cv_prev = 1'b0, sck_prev = 1'b0, sdi_prev = 1'b0;
    logic [2:0]        rq_ch[$];
    logic [DATA_W-1:0] rq_data[$];
    logic              rq_done[$];
    int                rq_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (adc_bus.adc_convst && !cv_prev) begin
            if (cv_rise_cyc >= 0) period = cyc - cv_rise_cyc;
            cv_rise_cyc = cyc;
            rises = 0;
            conv_cnt++;
        end
        if (!adc_bus.adc_convst && cv_prev) cv_width = cyc - cv_rise_cyc;
        if (adc_bus.adc_sck && !sck_prev) begin
            if (rises == 0) first_off = cyc - cv_rise_cyc;
            else if (cyc - sck_fall_cyc != CLK_DIV) hw_err++;
            rises++;
            sck_rise_cyc = cyc;
        end
        if (!adc_bus.adc_sck && sck_prev) begin
            if (cyc - sck_rise_cyc != CLK_DIV) hw_err++;
            sck_fall_cyc = cyc;
        end
        if (adc_bus.adc_sck && sck_prev && (adc_bus.adc_sdi !== sdi_prev)) sdi_err++;
        if (res_valid === 1'b1) begin
            rq_ch.push_back(res_ch);
            rq_data.push_back(res_data);
            rq_done.push_back(scan_done);
            rq_cyc.push_back(cyc);
        end
        cv_prev  = adc_bus.adc_convst;
        sck_prev = adc_bus.adc_sck;
        sdi_prev = adc_bus.adc_sdi;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ch(input int i);
        return (i < rq_ch.size()) ? 32'(rq_ch[i]) : 32'hDEAD;
    endfunction
    function automatic logic [31:0] r_data(input int i);
        return (i < rq_data.size()) ? 32'(rq_data[i]) : 32'hDEAD;
    endfunction
    function automatic logic [31:0] r_done(input int i);
        return (i < rq_done.size()) ? 32'(rq_done[i]) : 32'hDEAD;
    endfunction
    function automatic logic [31:0] r_sdi(input int i);
        return (i < sdi_q.size()) ? 32'(sdi_q[i]) : 32'hDEAD;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int n = 0; n < budget && busy !== 1'b0; n++) @(negedge clk);
        chk(tag, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, adc_bus.adc_convst, adc_bus.adc_sck, adc_bus.adc_sdi,
                    res_valid, scan_done, res_ch, res_data});
    endfunction

    int rb, sb, cb, hb, db, gap_bad;

    initial begin
        // reset state
        #5 chk("reset_outputs", outs(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk) chk("post_reset_idle", outs(), 32'd0);

        // single channel scan; start and mask/uni changes while busy are ignored
        rb = rq_ch.size(); sb = sdi_q.size(); cb = conv_cnt;
        ch_mask = 8'h01; uni = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("t1_busy_rise", 32'({busy, adc_bus.adc_convst}), 32'd3);
        repeat (100) @(negedge clk);
        ch_mask = 8'hFF; uni = 1'b1;
        pulse_start();
        wait_idle(1000, "t1_idle");
        chk("t1_nres", 32'(rq_ch.size() - rb), 32'd1);
        chk("t1_ch", r_ch(rb), 32'd0);
        chk("t1_data", r_data(rb), 32'hFFF);
        chk("t1_done", r_done(rb), 32'd1);
        chk("t1_frames", 32'(conv_cnt - cb), 32'd2);
        chk("t1_sdi0", r_sdi(sb), 32'b100000);
        chk("t1_sdi1", r_sdi(sb + 1), 32'b100000);

        // empty mask: start has no effect
        cb = conv_cnt;
        ch_mask = 8'h00;
        pulse_start();
        repeat (200) @(negedge clk);
        chk("t6_mask0_busy", 32'(busy), 32'd0);
        chk("t6_mask0_convst", 32'(conv_cnt - cb), 32'd0);

        // sparse mask with uni=1, plus pin timing
        rb = rq_ch.size(); sb = sdi_q.size(); cb = conv_cnt; hb = hw_err; db = sdi_err;
        ch_mask = 8'b1010_0100; uni = 1'b1;
        pulse_start();
        wait_idle(1500, "t3_idle");
        chk("t3_frames", 32'(conv_cnt - cb), 32'd4);
        chk("t3_sdi0", r_sdi(sb), 32'b100110);
        chk("t3_sdi1", r_sdi(sb + 1), 32'b111010);
        chk("t3_sdi2", r_sdi(sb + 2), 32'b111110);
        chk("t3_sdi_flush", r_sdi(sb + 3), 32'b100110);
        chk("t3_nres", 32'(rq_ch.size() - rb), 32'd3);
        chk("t3_ch_a", r_ch(rb), 32'd2);
        chk("t3_data_a", r_data(rb), 32'hDDD);
        chk("t3_done_a", r_done(rb), 32'd0);
        chk("t3_ch_b", r_ch(rb + 1), 32'd5);
        chk("t3_data_b", r_data(rb + 1), 32'hAAA);
        chk("t3_done_b", r_done(rb + 1), 32'd0);
        chk("t3_ch_c", r_ch(rb + 2), 32'd7);
        chk("t3_data_c", r_data(rb + 2), 32'h888);
        chk("t3_done_c", r_done(rb + 2), 32'd1);
        chk("t4_convst_width", 32'(cv_width), 32'(CONVST_CYC));
        chk("t4_first_sck", 32'(first_off), 32'(CONV_CYC));
        chk("t4_rises", 32'(rises), 32'(DATA_W));
        chk("t4_period", 32'(period), 32'd138);
        chk("t4_sck_width_err", 32'(hw_err - hb), 32'd0);
        chk("t4_sdi_change_err", 32'(sdi_err - db), 32'd0);

        // continuous scan over all channels
        rb = rq_ch.size();
        ch_mask = 8'hFF; uni = 1'b0;
        @(negedge clk) en = 1'b1;
        for (int n = 0; n < 20 * FRAME && rq_ch.size() < rb + 16; n++) @(negedge clk);
        en = 1'b0;
        chk("t2_got16", 32'(rq_ch.size() >= rb + 16), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_ch", r_ch(rb + i), 32'(i % 8));
            chk("t2_data", r_data(rb + i), 32'(12'hFFF - 12'h111 * 12'(i % 8)));
            chk("t2_done", r_done(rb + i), 32'(i % 8 == 7));
        end
        gap_bad = 0;
        for (int i = 1; i < 16; i++)
            if (rb + i < rq_cyc.size() && rq_cyc[rb + i] - rq_cyc[rb + i - 1] != FRAME) gap_bad++;
        chk("t2_no_gaps", 32'(gap_bad), 32'd0);
        wait_idle(12 * FRAME, "t2_idle_after_en");
        chk("t2_total", 32'(rq_ch.size() - rb), 32'd24);
        chk("t2_last_ch", r_ch(rb + 23), 32'd7);
        chk("t2_last_done", r_done(rb + 23), 32'd1);

        // asynchronous reset in the middle of a frame
        ch_mask = 8'hFF;
        pulse_start();
        for (int n = 0; n < 500 && adc_bus.adc_sck !== 1'b1; n++) @(negedge clk);
        chk("t5_sck_seen", 32'(adc_bus.adc_sck), 32'd1);
        #3 rst_n = 1'b0;
        #1 chk("t5_async_reset", outs(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rb = rq_ch.size();
        ch_mask = 8'h01;
        pulse_start();
        wait_idle(1000, "t5_idle");
        chk("t5_nres", 32'(rq_ch.size() - rb), 32'd1);
        chk("t5_ch", r_ch(rb), 32'd0);
        chk("t5_data", r_data(rb), 32'hFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
